// File: rtl/bias_add_sched_if.sv
// Handshake and adder-port bundle for bias_add_sched: bias writes, input row,
// output row and the shared FP32 adder driver.
interface bias_add_sched_if #(
  parameter int N_LANES = 4
);
  localparam int IDX_W = $clog2(N_LANES);

  logic                    bias_we;
  logic [IDX_W-1:0]        bias_idx;
  logic [31:0]             bias_wdata;
  logic                    bias_wr_err;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_bypass;
  logic [32*N_LANES-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [32*N_LANES-1:0]   out_data;
  logic                    add_start;
  logic [31:0]             add_a;
  logic [31:0]             add_b;
  logic                    add_busy;
  logic                    add_done;
  logic [31:0]             add_z;

  modport slave (
    input  bias_we, bias_idx, bias_wdata, in_valid, in_bypass, in_data,
           out_ready, add_busy, add_done, add_z,
    output bias_wr_err, in_ready, out_valid, out_data, add_start, add_a, add_b
  );

  modport master (
    output bias_we, bias_idx, bias_wdata, in_valid, in_bypass, in_data,
           out_ready, add_busy, add_done, add_z,
    input  bias_wr_err, in_ready, out_valid, out_data, add_start, add_a, add_b
  );
endinterface

// File: rtl/bias_add_sched.sv
// Adds a per-lane FP32 bias to a partial-sum row by sequencing one shared
// adder driver lane by lane; optional pass-through of the row unmodified.
module bias_add_sched #(
  parameter int N_LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bias_add_sched_if.slave   bus
);
  localparam int IDX_W = $clog2(N_LANES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              lane_q, lane_d;
  logic [N_LANES-1:0][31:0]      row_q, row_d;
  logic [N_LANES-1:0][31:0]      bias_q, bias_d;
  logic                          err_q, err_d;
  logic                          add_start;
  logic                          done_ok;

  // A done that is still high from the previous lane is ignored because the
  // driver raises busy the cycle after each start.
  assign done_ok = bus.add_done && !bus.add_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      row_q   <= '0;
      bias_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      row_q   <= row_d;
      bias_q  <= bias_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    row_d     = row_q;
    bias_d    = bias_q;
    err_d     = 1'b0;
    add_start = 1'b0;
    if (state_q == IDLE) begin
      if (bus.bias_we) bias_d[bus.bias_idx] = bus.bias_wdata;
    end else begin
      err_d = bus.bias_we;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          row_d   = bus.in_data;
          lane_d  = '0;
          state_d = bus.in_bypass ? OUT : ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.add_busy) begin
          add_start = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (done_ok) begin
          row_d[lane_q] = bus.add_z;
          if (lane_q == IDX_W'(N_LANES - 1)) begin
            state_d = OUT;
          end else begin
            lane_d  = lane_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are only driven while a lane is in flight; row/bias for the
  // current lane cannot change until WAIT exits, so they hold on their own.
  assign bus.add_start   = add_start;
  assign bus.add_a       = (state_q == ISSUE || state_q == WAIT) ? row_q[lane_q]  : 32'h0;
  assign bus.add_b       = (state_q == ISSUE || state_q == WAIT) ? bias_q[lane_q] : 32'h0;
  assign bus.in_ready    = rst_n && (state_q == IDLE);
  assign bus.out_valid   = (state_q == OUT);
  assign bus.out_data    = row_q;
  assign bus.bias_wr_err = err_q;
endmodule

// File: tb/tb_bias_add_sched.sv
// Scoreboard bench for bias_add_sched with a behavioural multi-cycle FP32
// adder driver; expected rows are queued at drive time and checked on output.
module tb_bias_add_sched;
  localparam int N   = 4;
  localparam int W   = 32 * N;
  localparam int L   = 3;
  localparam int LAT = N * (1 + L) + 1;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bias_add_sched_if #(.N_LANES(N)) bif ();
  bias_add_sched #(.N_LANES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int starts = 0;
  int acc_cyc = 0;
  int lat_meas = 0;
  bit lat_seen = 1'b0;
  exp_t sb[$];
  logic [31:0] shadow [N];

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Behavioural adder driver: busy the cycle after start, done level held
  // until the next start is accepted.
  int          a_cnt = 0;
  logic [31:0] a_a, a_b;
  always @(posedge clk) begin
    if (!rst_n) begin
      bif.add_busy <= 1'b0;
      bif.add_done <= 1'b0;
      bif.add_z    <= 32'h0;
      a_cnt        <= 0;
    end else if (bif.add_start && !bif.add_busy) begin
      bif.add_busy <= 1'b1;
      bif.add_done <= 1'b0;
      a_a          <= bif.add_a;
      a_b          <= bif.add_b;
      a_cnt        <= L - 1;
    end else if (bif.add_busy) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) begin
        bif.add_busy <= 1'b0;
        bif.add_done <= 1'b1;
        bif.add_z    <= fp_add(a_a, a_b);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (bif.add_start) starts <= starts + 1;
    if (bif.in_valid && bif.in_ready) begin
      acc_cyc  = cyc;
      lat_seen = 1'b0;
    end
    if (bif.out_valid && !lat_seen) begin
      lat_meas = cyc - acc_cyc;
      lat_seen = 1'b1;
    end
    if (rst_n && bif.out_valid && bif.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_data", bif.out_data, e.data);
        chk("latency", lat_meas, e.lat);
      end
    end
  end

  task automatic write_bias(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    bif.bias_we = 1'b1; bif.bias_idx = 2'(idx); bif.bias_wdata = v;
    shadow[idx] = v;
    @(posedge clk); #1;
    bif.bias_we = 1'b0;
  endtask

  task automatic send_row(input logic [W-1:0] d, input logic byp, input logic [W-1:0] e,
                          input int lat, input logic we, input int wi, input logic [31:0] wd);
    bit ok;
    @(posedge clk); #1;
    bif.in_valid = 1'b1; bif.in_data = d; bif.in_bypass = byp;
    bif.bias_we = we; bif.bias_idx = 2'(wi); bif.bias_wdata = wd;
    if (we) shadow[wi] = wd;
    sb.push_back('{e, lat});
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bif.in_ready) begin ok = 1'b1; break; end
    end
    chk("accept", W'(ok), W'(1));
    @(posedge clk); #1;
    bif.in_valid = 1'b0; bif.bias_we = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain", W'(sb.size()), W'(0));
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] row, exp;
    int base;
    bif.bias_we = 0; bif.bias_idx = 0; bif.bias_wdata = 0;
    bif.in_valid = 0; bif.in_bypass = 0; bif.in_data = '0; bif.out_ready = 1;
    for (int i = 0; i < N; i++) shadow[i] = 32'h0;

    // reset state
    #12;
    chk("rst_in_ready", W'(bif.in_ready), W'(0));
    chk("rst_out_valid", W'(bif.out_valid), W'(0));
    chk("rst_add_start", W'(bif.add_start), W'(0));
    chk("rst_err", W'(bif.bias_wr_err), W'(0));
    chk("rst_add_ab", {bif.add_a, bif.add_b}, '0);
    chk("rst_out_data", bif.out_data, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", W'(bif.in_ready), W'(1));

    // 1: 0.5 + 1.0 on every lane
    for (int i = 0; i < N; i++) write_bias(i, 32'h3F800000);
    base = starts;
    send_row({N{32'h3F000000}}, 1'b0, {N{32'h3FC00000}}, LAT, 1'b0, 0, 0);
    wait_drain();
    chk("t1_starts", W'(starts - base), W'(N));

    // 2: 2.0 + -2.0 -> +0; last bias written in the same cycle as the row
    for (int i = 0; i < N - 1; i++) write_bias(i, 32'hC0000000);
    base = starts;
    send_row({N{32'h40000000}}, 1'b0, '0, LAT, 1'b1, N - 1, 32'hC0000000);
    wait_drain();
    chk("t2_starts", W'(starts - base), W'(N));

    // 3: bypass
    base = starts;
    row = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    send_row(row, 1'b1, row, 1, 1'b0, 0, 0);
    wait_drain();
    chk("t3_starts", W'(starts - base), W'(0));

    // 4: output backpressure
    for (int i = 0; i < N; i++) begin
      row[32*i+:32] = rnd_fp();
      exp[32*i+:32] = fp_add(row[32*i+:32], shadow[i]);
    end
    bif.out_ready = 1'b0;
    send_row(row, 1'b0, exp, LAT, 1'b0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bif.out_valid) break;
    end
    chk("t4_out_valid", W'(bif.out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", W'(bif.out_valid), W'(1));
      chk("t4_hold_data", bif.out_data, exp);
      chk("t4_in_ready", W'(bif.in_ready), W'(0));
    end
    bif.out_ready = 1'b1;
    wait_drain();
    chk("t4_idle", W'(bif.in_ready), W'(1));

    // 5: bias write while busy is dropped; lane 3 still uses the old bias
    for (int i = 0; i < N; i++) begin
      row[32*i+:32] = rnd_fp();
      exp[32*i+:32] = fp_add(row[32*i+:32], shadow[i]);
    end
    base = starts;
    send_row(row, 1'b0, exp, LAT, 1'b0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (starts > base) break;
    end
    @(posedge clk); #1;
    bif.bias_we = 1'b1; bif.bias_idx = 2'(N - 1); bif.bias_wdata = 32'h12345678;
    @(posedge clk); #1;
    bif.bias_we = 1'b0;
    @(negedge clk);
    chk("t5_err_pulse", W'(bif.bias_wr_err), W'(1));
    @(negedge clk);
    chk("t5_err_clear", W'(bif.bias_wr_err), W'(0));
    wait_drain();

    // 6: reset in the middle of lane 2
    for (int i = 0; i < N; i++) row[32*i+:32] = rnd_fp();
    base = starts;
    send_row(row, 1'b0, row, LAT, 1'b0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (starts >= base + 3) break;
    end
    chk("t6_reach_lane2", W'(starts - base), W'(3));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", W'(bif.out_valid), W'(0));
    chk("t6_in_ready", W'(bif.in_ready), W'(0));
    chk("t6_add_a", W'(bif.add_a), W'(0));
    chk("t6_out_data", bif.out_data, '0);
    sb.delete();
    for (int i = 0; i < N; i++) shadow[i] = 32'h0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle", W'(bif.in_ready), W'(1));
    for (int i = 0; i < N; i++) row[32*i+:32] = rnd_fp();
    base = starts;
    send_row(row, 1'b0, row, LAT, 1'b0, 0, 0);
    wait_drain();
    chk("t6_starts", W'(starts - base), W'(N));

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
